// File: rtl/bram_frame_reader.sv
// bram_frame_reader: streams one FRAME_WIDTH x FRAME_HEIGHT frame out of a
// BRAM with combinational read data, using a valid/ready output handshake.
// The read address is always y*FRAME_WIDTH + x and advances only when a new
// pixel is loaded into the output register, so backpressure never drops or
// repeats a beat.
// Build option: define FRAME_READER_LOOP_EN for continuous back-to-back
// frames (the block stays in RUN and wraps to address 0 after each eof).
// Without it, each start produces exactly one frame.
module bram_frame_reader #(
    parameter int FRAME_WIDTH     = 720,
    parameter int FRAME_HEIGHT    = 540,
    parameter int BRAM_DATA_WIDTH = 12,
    parameter int BRAM_ADDR_WIDTH = 19
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    output logic [BRAM_ADDR_WIDTH-1:0] rd_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_dout,
    output logic [BRAM_DATA_WIDTH-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sof,
    output logic                       out_eol,
    output logic                       out_eof,
    output logic                       busy,
    output logic                       done
);

    localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

    // A whole frame has to be addressable by the BRAM port.
    if (FRAME_WIDTH * FRAME_HEIGHT > 2 ** BRAM_ADDR_WIDTH) begin : g_size_check
        $error("bram_frame_reader: frame does not fit in BRAM_ADDR_WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [XW-1:0]              x_q, x_d;
    logic [YW-1:0]              y_q, y_d;
    logic [BRAM_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_sof_q, out_sof_d;
    logic                       out_eol_q, out_eol_d;
    logic                       out_eof_q, out_eof_d;

    logic xfer;
    logic load;
    logic x_last;
    logic y_last;

    // Next-state logic: frame counters, output register loading and FSM.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        x_d         = x_q;
        y_d         = y_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sof_d   = out_sof_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;

        xfer   = out_valid_q && out_ready;
        load   = (state_q == ST_RUN) && (!out_valid_q || out_ready);
        x_last = (x_q == X_LAST);
        y_last = (y_q == Y_LAST);

        case (state_q)
            ST_IDLE: begin
                rd_addr_d = '0;
                x_d       = '0;
                y_d       = '0;
                if (start) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // A transfer without a load cannot happen here: ready always
                // makes room for the next pixel in the same cycle.
                if (load) begin
                    out_data_d  = bram_dout;
                    out_valid_d = 1'b1;
                    out_sof_d   = (x_q == '0) && (y_q == '0);
                    out_eol_d   = x_last;
                    out_eof_d   = x_last && y_last;
                    if (x_last && y_last) begin
                        rd_addr_d = '0;
                        x_d       = '0;
                        y_d       = '0;
`ifdef FRAME_READER_LOOP_EN
                        state_d   = ST_RUN;
`else
                        state_d   = ST_DRAIN;
`endif
                    end else if (x_last) begin
                        rd_addr_d = rd_addr_q + 1'b1;
                        x_d       = '0;
                        y_d       = y_q + 1'b1;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                        x_d       = x_q + 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                // Hold the eof pixel until downstream takes it.
                if (xfer) begin
                    out_valid_d = 1'b0;
                    out_sof_d   = 1'b0;
                    out_eol_d   = 1'b0;
                    out_eof_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and output register; reset abandons any partial frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
        end
    end

    // Outputs; done marks the cycle in which the eof pixel is accepted.
    always_comb begin
        rd_addr   = rd_addr_q;
        out_data  = out_data_q;
        out_valid = out_valid_q;
        out_sof   = out_sof_q;
        out_eol   = out_eol_q;
        out_eof   = out_eof_q;
        busy      = (state_q != ST_IDLE);
        done      = out_valid_q && out_ready && out_eof_q;
    end

endmodule

// File: tb/tb_bram_frame_reader.sv
// Testbench for bram_frame_reader on a 4x3 frame with BRAM contents mem[a]=a.
// Expected beats are queued when a frame is started and checked as the DUT
// hands them over.
module tb_bram_frame_reader;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 12;
    localparam int AW = 19;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] bram_dout;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;
    logic          busy;
    logic          done;

    beat_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    bram_frame_reader #(
        .FRAME_WIDTH    (W),
        .FRAME_HEIGHT   (H),
        .BRAM_DATA_WIDTH(DW),
        .BRAM_ADDR_WIDTH(AW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .rd_addr  (rd_addr),
        .bram_dout(bram_dout),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sof  (out_sof),
        .out_eol  (out_eol),
        .out_eof  (out_eof),
        .busy     (busy),
        .done     (done)
    );

    // BRAM model: each location holds its own address.
    assign bram_dout = rd_addr[DW-1:0];

    always #5 clock = ~clock;

    task automatic push_frame();
        beat_t b;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                b.d   = DW'(y * W + x);
                b.sof = (x == 0) && (y == 0);
                b.eol = (x == W - 1);
                b.eof = (x == W - 1) && (y == H - 1);
                sb.push_back(b);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got %b exp 0", out_valid);
        end
        n_vec++;
        if (rd_addr !== '0 || out_data !== '0) begin
            n_err++; $display("FAIL reset_addr_data got %h/%h exp 0/0", rd_addr, out_data);
        end
        n_vec++;
        if ({out_sof, out_eol, out_eof} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags got %b exp 000", {out_sof, out_eol, out_eof});
        end
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL reset_busy_done got %b exp 00", {busy, done});
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_stream();
        beat_t b, obs;
        int    first, beats, dones;
        sb.delete();
        push_frame();
        @(negedge clock);
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL stream_latency valid/busy got %b%b exp 01", out_valid, busy);
        end
        first = -1; beats = 0; dones = 0;
        for (int c = 2; c < 40 && sb.size() > 0; c++) begin
            @(negedge clock);
            #1;
            if (out_valid && out_ready) begin
                if (first < 0) first = c;
                b = sb.pop_front();
                obs = '{out_data, out_sof, out_eol, out_eof};
                n_vec++;
                if (obs !== b) begin
                    n_err++; $display("FAIL stream_beat got %h exp %h", obs, b);
                end
                n_vec++;
                if (c !== first + beats) begin
                    n_err++; $display("FAIL stream_gap beat %0d at cycle %0d exp %0d", beats, c, first + beats);
                end
                beats++;
            end
            if (done) dones++;
        end
        n_vec++;
        if (first !== 2) begin
            n_err++; $display("FAIL stream_first_cycle got %0d exp 2", first);
        end
        n_vec++;
        if (beats !== W * H || sb.size() !== 0) begin
            n_err++; $display("FAIL stream_count got %0d exp %0d", beats, W * H);
        end
        n_vec++;
        if (dones !== 1) begin
            n_err++; $display("FAIL stream_done got %0d exp 1", dones);
        end
        @(negedge clock);
        #1;
        n_vec++;
        if ({busy, done, out_valid} !== 3'b000) begin
            n_err++; $display("FAIL stream_after busy/done/valid got %b exp 000", {busy, done, out_valid});
        end
    endtask

    task automatic test_backpressure();
        beat_t         b, obs;
        int            dones;
        bit            prev_stall;
        logic [DW-1:0] prev_data;
        logic [3:0]    pat;
        pat = 4'b1001;
        sb.delete();
        push_frame();
        @(negedge clock);
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        dones = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 2; c < 80 && sb.size() > 0; c++) begin
            @(negedge clock);
            out_ready = pat[3 - (c % 4)];
            #1;
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    n_err++; $display("FAIL bp_hold got %b/%h exp 1/%h", out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                b = sb.pop_front();
                obs = '{out_data, out_sof, out_eol, out_eof};
                n_vec++;
                if (obs !== b) begin
                    n_err++; $display("FAIL bp_beat got %h exp %h", obs, b);
                end
            end
            if (done) dones++;
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
        n_vec++;
        if (sb.size() !== 0) begin
            n_err++; $display("FAIL bp_timeout remaining %0d exp 0", sb.size());
        end
        n_vec++;
        if (dones !== 1) begin
            n_err++; $display("FAIL bp_done got %0d exp 1", dones);
        end
        out_ready = 1'b1;
        @(negedge clock);
        #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL bp_busy_after got %b exp 0", busy);
        end
    endtask

    task automatic test_start_ignored();
        beat_t b, obs;
        int    dones, extra;
        sb.delete();
        push_frame();
        @(negedge clock);
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        dones = 0; extra = 0;
        for (int c = 2; c < 40 && sb.size() > 0; c++) begin
            @(negedge clock);
            start = (c == 7);
            #1;
            if (out_valid && out_ready) begin
                b = sb.pop_front();
                obs = '{out_data, out_sof, out_eol, out_eof};
                n_vec++;
                if (obs !== b) begin
                    n_err++; $display("FAIL restart_beat got %h exp %h", obs, b);
                end
            end
            if (done) dones++;
        end
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            #1;
            if (out_valid || busy) extra++;
            if (done) dones++;
        end
        n_vec++;
        if (sb.size() !== 0 || extra !== 0) begin
            n_err++; $display("FAIL restart_single_frame remaining/extra got %0d/%0d exp 0/0", sb.size(), extra);
        end
        n_vec++;
        if (dones !== 1) begin
            n_err++; $display("FAIL restart_done got %0d exp 1", dones);
        end
    endtask

    task automatic test_eof_stall();
        beat_t b, obs;
        int    dones, done_cyc;
        sb.delete();
        push_frame();
        @(negedge clock);
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        dones = 0; done_cyc = -1;
        for (int c = 2; c < 40 && sb.size() > 0; c++) begin
            @(negedge clock);
            out_ready = !(c >= 13 && c < 18);
            #1;
            if (c >= 13 && c < 18) begin
                n_vec++;
                if ({out_valid, out_eof, done} !== 3'b110 || out_data !== DW'(11)) begin
                    n_err++; $display("FAIL eof_stall valid/eof/done got %b data %0d exp 110 data 11",
                                      {out_valid, out_eof, done}, out_data);
                end
            end
            if (out_valid && out_ready) begin
                b = sb.pop_front();
                obs = '{out_data, out_sof, out_eol, out_eof};
                n_vec++;
                if (obs !== b) begin
                    n_err++; $display("FAIL eof_beat got %h exp %h", obs, b);
                end
            end
            if (done) begin
                dones++;
                done_cyc = c;
            end
        end
        n_vec++;
        if (dones !== 1 || done_cyc !== 18) begin
            n_err++; $display("FAIL eof_done count/cycle got %0d/%0d exp 1/18", dones, done_cyc);
        end
        out_ready = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset_midframe();
        beat_t b, obs;
        int    first, dones, stray;
        sb.delete();
        push_frame();
        @(negedge clock);
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 2; c < 8; c++) begin
            @(negedge clock);
            #1;
            if (out_valid && out_ready) begin
                b = sb.pop_front();
                obs = '{out_data, out_sof, out_eol, out_eof};
                n_vec++;
                if (obs !== b) begin
                    n_err++; $display("FAIL midrst_pre_beat got %h exp %h", obs, b);
                end
            end
        end
        @(negedge clock);
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== DW'(6)) begin
            n_err++; $display("FAIL midrst_at_pixel6 got %b/%0d exp 1/6", out_valid, out_data);
        end
        #1;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({out_valid, busy, done, out_sof, out_eol, out_eof} !== 6'b0 || rd_addr !== '0 || out_data !== '0) begin
            n_err++; $display("FAIL midrst_async got ctl %b addr %h data %h exp 0",
                              {out_valid, busy, done, out_sof, out_eol, out_eof}, rd_addr, out_data);
        end
        @(negedge clock);
        reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            #1;
            if (out_valid || busy || rd_addr !== '0) stray++;
        end
        n_vec++;
        if (stray !== 0) begin
            n_err++; $display("FAIL midrst_no_resume got %0d active cycles exp 0", stray);
        end
        sb.delete();
        push_frame();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        first = -1; dones = 0;
        for (int c = 2; c < 40 && sb.size() > 0; c++) begin
            @(negedge clock);
            #1;
            if (out_valid && out_ready) begin
                if (first < 0) first = c;
                b = sb.pop_front();
                obs = '{out_data, out_sof, out_eol, out_eof};
                n_vec++;
                if (obs !== b) begin
                    n_err++; $display("FAIL midrst_restart_beat got %h exp %h", obs, b);
                end
            end
            if (done) dones++;
        end
        n_vec++;
        if (first !== 2 || dones !== 1 || sb.size() !== 0) begin
            n_err++; $display("FAIL midrst_restart first/done/left got %0d/%0d/%0d exp 2/1/0",
                              first, dones, sb.size());
        end
        @(negedge clock);
    endtask

    task automatic test_loop();
        beat_t b, obs;
        int    first, beats, dones, not_busy;
        sb.delete();
        push_frame();
        push_frame();
        @(negedge clock);
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        first = -1; beats = 0; dones = 0; not_busy = 0;
        for (int c = 2; c < 60 && sb.size() > 0; c++) begin
            @(negedge clock);
            #1;
            if (busy !== 1'b1) not_busy++;
            if (out_valid && out_ready) begin
                if (first < 0) first = c;
                b = sb.pop_front();
                obs = '{out_data, out_sof, out_eol, out_eof};
                n_vec++;
                if (obs !== b) begin
                    n_err++; $display("FAIL loop_beat got %h exp %h", obs, b);
                end
                n_vec++;
                if (c !== first + beats) begin
                    n_err++; $display("FAIL loop_gap beat %0d at cycle %0d exp %0d", beats, c, first + beats);
                end
                beats++;
            end
            if (done) dones++;
        end
        n_vec++;
        if (beats !== 2 * W * H || dones !== 2) begin
            n_err++; $display("FAIL loop_count beats/done got %0d/%0d exp %0d/2", beats, dones, 2 * W * H);
        end
        repeat (3) begin
            @(negedge clock);
            #1;
            if (busy !== 1'b1) not_busy++;
        end
        n_vec++;
        if (not_busy !== 0) begin
            n_err++; $display("FAIL loop_busy got %0d idle cycles exp 0", not_busy);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        test_reset();
`ifdef FRAME_READER_LOOP_EN
        test_loop();
`else
        test_stream();
        test_backpressure();
        test_start_ignored();
        test_eof_stall();
        test_reset_midframe();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
